// File: rtl/uart_tx_arbiter_if.sv
// ============================================================================
// Module  : uart_tx_arbiter_if
// Brief   : Requester/UART-side bundle of the UART transmit arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_tx_arbiter_if #(
  parameter int WORD_LENGTH = 8,
  parameter int NUM_REQ     = 4
);
  logic [NUM_REQ-1:0]             req;
  logic [NUM_REQ*WORD_LENGTH-1:0] data_in;
  logic [NUM_REQ-1:0]             grant;
  logic [$clog2(NUM_REQ)-1:0]     owner;
  logic [WORD_LENGTH-1:0]         DATATX;
  logic                           Transmit;
  logic                           busy;

  // Producer side: drives requests and bytes, observes grants and UART feed.
  modport master (
    output req, data_in,
    input  grant, owner, DATATX, Transmit, busy
  );

  // Arbiter side.
  modport slave (
    input  req, data_in,
    output grant, owner, DATATX, Transmit, busy
  );
endinterface

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
// ============================================================================
// Module  : uart_tx_arbiter
// Brief   : Round-robin share of one UART transmitter; holds off for a frame.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_arbiter #(
  parameter int WORD_LENGTH  = 8,
  parameter int NUM_REQ      = 4,
  parameter int FRAME_CYCLES = 1024
) (
  input  wire              clk,
  input  wire              reset,
  uart_tx_arbiter_if.slave bus
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(FRAME_CYCLES + 1);

  typedef logic [IW-1:0]          idx_t;
  typedef logic [NUM_REQ-1:0]     req_t;
  typedef logic [CW-1:0]          cnt_t;
  typedef logic [WORD_LENGTH-1:0] word_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_SEND = 2'd2
  } state_t;

  localparam cnt_t CNT_LOAD = cnt_t'(FRAME_CYCLES - 1);
  localparam idx_t LAST_RST = idx_t'(NUM_REQ - 1);

  state_t state_q, state_d;
  req_t   grant_q, grant_d;
  idx_t   owner_q, owner_d;
  idx_t   last_q,  last_d;
  word_t  datatx_q, datatx_d;
  logic   transmit_q, transmit_d;
  logic   busy_q, busy_d;
  cnt_t   cnt_q, cnt_d;

  logic   win_found;
  idx_t   win_idx;
  idx_t   cand;

  // Search starts just after the last winner so every requester gets a turn.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = idx_t'((int'(last_q) + k) % NUM_REQ);
      if (!win_found && bus.req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = '0;
    owner_d    = owner_q;
    last_d     = last_q;
    datatx_d   = datatx_q;
    transmit_d = 1'b0;
    cnt_d      = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          grant_d  = req_t'(1) << win_idx;
          owner_d  = win_idx;
          last_d   = win_idx;
          datatx_d = bus.data_in[win_idx*WORD_LENGTH +: WORD_LENGTH];
          state_d  = S_LOAD;
        end
      end
      S_LOAD: begin
        transmit_d = 1'b1;
        cnt_d      = CNT_LOAD;
        state_d    = S_SEND;
      end
      S_SEND: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - cnt_t'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      grant_q    <= '0;
      owner_q    <= '0;
      last_q     <= LAST_RST;
      datatx_q   <= '0;
      transmit_q <= 1'b0;
      busy_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      datatx_q   <= datatx_d;
      transmit_q <= transmit_d;
      busy_q     <= busy_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.grant    = grant_q;
  assign bus.owner    = owner_q;
  assign bus.DATATX   = datatx_q;
  assign bus.Transmit = transmit_q;
  assign bus.busy     = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// ============================================================================
// Module  : tb_uart_tx_arbiter
// Brief   : Directed self-checking bench for uart_tx_arbiter (4 req, 12-cycle frame).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_arbiter;

  localparam int WL = 8;
  localparam int NR = 4;
  localparam int FC = 12;

  logic clk;
  logic reset;
  int   chk_cnt;
  int   err_cnt;
  int   cyc;

  uart_tx_arbiter_if #(.WORD_LENGTH(WL), .NUM_REQ(NR)) arb_if ();

  uart_tx_arbiter #(
    .WORD_LENGTH  (WL),
    .NUM_REQ      (NR),
    .FRAME_CYCLES (FC)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (arb_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_grant(input int max_cyc);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (arb_if.grant != '0) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check("grant_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle(input int max_cyc);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (!arb_if.busy) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic set_byte(input int idx, input logic [WL-1:0] b);
    arb_if.data_in[idx*WL +: WL] = b;
  endtask

  initial begin
    int g_prev;
    int bcnt;
    bit bad;

    chk_cnt        = 0;
    err_cnt        = 0;
    reset          = 1'b0;
    arb_if.req     = '0;
    arb_if.data_in = '0;

    // 1: reset held with all requests up
    arb_if.req = 4'hF;
    set_byte(0, 8'h11); set_byte(1, 8'h22); set_byte(2, 8'h33); set_byte(3, 8'h44);
    repeat (3) @(negedge clk);
    check("rst_grant",    32'(arb_if.grant),    32'h0);
    check("rst_owner",    32'(arb_if.owner),    32'h0);
    check("rst_datatx",   32'(arb_if.DATATX),   32'h0);
    check("rst_transmit", 32'(arb_if.Transmit), 32'h0);
    check("rst_busy",     32'(arb_if.busy),     32'h0);
    reset = 1'b1;
    wait_grant(1);
    check("t1_grant",  32'(arb_if.grant),  32'h1);
    check("t1_datatx", 32'(arb_if.DATATX), 32'h11);
    arb_if.req = '0;
    wait_idle(30);

    // 2: lone requester 2, latency and busy length
    set_byte(2, 8'hA5);
    arb_if.req = 4'b0100;
    wait_grant(3);
    check("t2_grant",  32'(arb_if.grant),  32'h4);
    check("t2_datatx", 32'(arb_if.DATATX), 32'hA5);
    check("t2_owner",  32'(arb_if.owner),  32'h2);
    check("t2_tx_early", 32'(arb_if.Transmit), 32'h0);
    arb_if.req = '0;
    bcnt = arb_if.busy ? 1 : 0;
    @(negedge clk);
    check("t2_transmit", 32'(arb_if.Transmit), 32'h1);
    check("t2_grant_off", 32'(arb_if.grant), 32'h0);
    if (arb_if.busy) bcnt++;
    @(negedge clk);
    check("t2_tx_pulse", 32'(arb_if.Transmit), 32'h0);
    for (int i = 0; i < 40 && arb_if.busy; i++) begin
      bcnt++;
      @(negedge clk);
    end
    check("t2_busy_len", 32'(bcnt), 32'(FC + 1));

    // 3: all requesters, fresh pointer, strict rotation
    @(negedge clk); reset = 1'b0;
    set_byte(0, 8'hC0); set_byte(1, 8'hC1); set_byte(2, 8'hC2); set_byte(3, 8'hC3);
    arb_if.req = 4'hF;
    @(negedge clk); reset = 1'b1;
    g_prev = 0;
    for (int n = 0; n < 5; n++) begin
      wait_grant(20);
      check($sformatf("t3_grant%0d", n), 32'(arb_if.grant), 32'(1 << (n % NR)));
      if (n > 0) check($sformatf("t3_space%0d", n), 32'(cyc - g_prev), 32'(FC + 2));
      g_prev = cyc;
      if (n == 4) arb_if.req = '0;
      @(negedge clk);
      check($sformatf("t3_tx%0d", n), 32'(arb_if.Transmit), 32'h1);
      check($sformatf("t3_data%0d", n), 32'(arb_if.DATATX), 32'(8'hC0 + (n % NR)));
    end
    wait_idle(30);

    // 4: wrap from requester 3 to 0, then 3 again
    arb_if.req = 4'b1000;
    wait_grant(3);
    check("t4_pre", 32'(arb_if.grant), 32'h8);
    arb_if.req = '0;
    wait_idle(30);
    arb_if.req = 4'b1001;
    wait_grant(3);
    check("t4_wrap", 32'(arb_if.grant), 32'h1);
    wait_grant(20);
    check("t4_next", 32'(arb_if.grant), 32'h8);
    check("t4_owner", 32'(arb_if.owner), 32'h3);
    arb_if.req = '0;
    wait_idle(30);

    // 5: data and request changes during SEND are ignored
    set_byte(1, 8'h5A);
    arb_if.req = 4'b0010;
    wait_grant(3);
    check("t5_grant", 32'(arb_if.grant), 32'h2);
    arb_if.req = '0;
    repeat (4) @(negedge clk);
    set_byte(1, 8'hFF);
    arb_if.req = 4'b0001;
    @(negedge clk);
    arb_if.req = '0;
    bad = 1'b0;
    for (int i = 0; i < 30 && arb_if.busy; i++) begin
      if (arb_if.grant != '0 || arb_if.Transmit || arb_if.DATATX != 8'h5A) bad = 1'b1;
      @(negedge clk);
    end
    check("t5_quiet", 32'(bad), 32'h0);
    repeat (3) @(negedge clk);
    check("t5_no_grant", 32'(arb_if.grant), 32'h0);
    check("t5_datatx", 32'(arb_if.DATATX), 32'h5A);

    // 6: reset mid-frame, pending request restarts from requester 0 priority
    arb_if.req = 4'b0100;
    wait_grant(3);
    check("t6_grant", 32'(arb_if.grant), 32'h4);
    arb_if.req = 4'b0110;
    set_byte(1, 8'h77);
    repeat (7) @(negedge clk);
    check("t6_busy_mid", 32'(arb_if.busy), 32'h1);
    #1 reset = 1'b0;
    #1;
    check("t6_rst_busy",   32'(arb_if.busy),   32'h0);
    check("t6_rst_datatx", 32'(arb_if.DATATX), 32'h0);
    check("t6_rst_owner",  32'(arb_if.owner),  32'h0);
    @(negedge clk);
    reset = 1'b1;
    wait_grant(1);
    check("t6_regrant", 32'(arb_if.grant),  32'h2);
    check("t6_owner",   32'(arb_if.owner),  32'h1);
    check("t6_datatx",  32'(arb_if.DATATX), 32'h77);
    arb_if.req = '0;
    wait_idle(30);

    $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
